// File: rtl/div16x8_pkg.sv
// Shared constants for the 16x8 divider: FSM encodings, 7-segment patterns
// (active-low, bit order {a,b,c,d,e,f,g}) and the divide-by-zero quotient.
package div16x8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [15:0] DIV_ZERO_QUOTIENT = 16'hFFFF;
    localparam logic [3:0]  CNT_INIT          = 4'd15;
    localparam logic [3:0]  CODE_ERR          = 4'hE;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_seg_decoder.sv
// 4-bit code to active-low 7-segment pattern; shared with the multiplier.
// Codes without a glyph blank the display.
module seven_seg_decoder
    import div16x8_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:     seg_o = SEG_0;
            4'd1:     seg_o = SEG_1;
            4'd2:     seg_o = SEG_2;
            4'd3:     seg_o = SEG_3;
            4'd4:     seg_o = SEG_4;
            4'd5:     seg_o = SEG_5;
            4'd6:     seg_o = SEG_6;
            4'd7:     seg_o = SEG_7;
            4'd8:     seg_o = SEG_8;
            4'd9:     seg_o = SEG_9;
            CODE_ERR: seg_o = SEG_E;
            default:  seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/div16x8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock,
// with a registered 7-segment readout of the FSM state.
module div16x8
    import div16x8_pkg::*;
(
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient_out,
    output logic [7:0]  remainder_out,
    output logic        done_flag,
    output logic        div_by_zero,
    output logic        seg_a,
    output logic        seg_b,
    output logic        seg_c,
    output logic        seg_d,
    output logic        seg_e,
    output logic        seg_f,
    output logic        seg_g
);

    state_e      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] quot_q, quot_d;
    logic [7:0]  remo_q, remo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic [6:0]  seg_q, seg_dec;
    logic [3:0]  seg_code;

    // The shifted partial remainder needs 9 bits; after a successful subtract
    // it is below the divisor again, so only 8 bits are stored.
    logic [8:0]  rem_sh;
    logic        fits;
    assign rem_sh = {rem_q, quo_q[15]};
    assign fits   = (rem_sh >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                end
            end
            ST_LOAD: begin
                rem_d = '0;
                quo_d = dvd_q;
                cnt_d = CNT_INIT;
                if (dvs_q == 8'd0) begin
                    state_d = ST_DONE;
                    quot_d  = DIV_ZERO_QUOTIENT;
                    remo_d  = dvd_q[7:0];
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = fits ? (rem_sh[7:0] - dvs_q) : rem_sh[7:0];
                quo_d = {quo_q[14:0], fits};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    quot_d  = quo_d;
                    remo_d  = rem_d;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        seg_code = 4'd0;
        case (state_q)
            ST_IDLE: seg_code = 4'd0;
            ST_LOAD: seg_code = 4'd1;
            ST_CALC: seg_code = 4'd2;
            ST_DONE: seg_code = dbz_q ? CODE_ERR : 4'd3;
            default: seg_code = 4'd0;
        endcase
    end

    seven_seg_decoder u_seg (
        .code_i (seg_code),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            seg_q   <= SEG_0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            seg_q   <= seg_dec;
        end
    end

    assign quotient_out  = quot_q;
    assign remainder_out = remo_q;
    assign done_flag     = done_q;
    assign div_by_zero   = dbz_q;
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;

endmodule

// File: tb/tb_div16x8.sv
// Directed bench for div16x8: latency, results, divide-by-zero, reset abort,
// back-to-back operation with the segment readout, and a random sweep.
module tb_div16x8;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient_out;
    logic [7:0]  remainder_out;
    logic        done_flag;
    logic        div_by_zero;
    logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] PE = 7'b0110000;

    div16x8 dut (
        .clk           (clk),
        .reset_a       (reset_a),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .done_flag     (done_flag),
        .div_by_zero   (div_by_zero),
        .seg_a         (seg_a),
        .seg_b         (seg_b),
        .seg_c         (seg_c),
        .seg_d         (seg_d),
        .seg_e         (seg_e),
        .seg_f         (seg_f),
        .seg_g         (seg_g)
    );

    assign seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge (E0) and returns the number of edges after E0
    // until done_flag is seen; 40 means it never arrived.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        lat = 0;
        while (done_flag !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int          lat;
    int          first, second;
    logic [15:0] q1, q2;
    logic [7:0]  r1, r2;
    logic [6:0]  seg_log [0:39];
    int          no_done;
    logic [15:0] ra;
    logic [7:0]  rb;

    initial begin
        reset_a  = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset_a = 1'b0;
        chk("reset_q",    32'(quotient_out),  32'h0);
        chk("reset_r",    32'(remainder_out), 32'h0);
        chk("reset_done", 32'(done_flag),     32'h0);
        chk("reset_dbz",  32'(div_by_zero),   32'h0);
        chk("reset_seg",  32'(seg),           32'(P0));
        tick();

        // 65535 / 255 = 257 r 0
        do_op(16'hFFFF, 8'hFF, lat);
        chk("t1_latency", 32'(lat),           32'd17);
        chk("t1_q",       32'(quotient_out),  32'h0101);
        chk("t1_r",       32'(remainder_out), 32'h00);
        chk("t1_dbz",     32'(div_by_zero),   32'h0);
        tick();
        chk("t1_done_1cyc", 32'(done_flag),   32'h0);
        chk("t1_seg_done",  32'(seg),         32'(P3));
        tick();

        // 1000 / 7 = 142 r 6, then 3 / 16 = 0 r 3
        do_op(16'd1000, 8'd7, lat);
        chk("t2a_latency", 32'(lat),           32'd17);
        chk("t2a_q",       32'(quotient_out),  32'd142);
        chk("t2a_r",       32'(remainder_out), 32'd6);
        repeat (5) tick();
        chk("t2_hold_q",   32'(quotient_out),  32'd142);
        chk("t2_hold_r",   32'(remainder_out), 32'd6);
        do_op(16'd3, 8'd16, lat);
        chk("t2b_q",       32'(quotient_out),  32'd0);
        chk("t2b_r",       32'(remainder_out), 32'd3);
        tick();

        // 5 / 0: done right after LOAD, all-ones quotient, low dividend byte
        do_op(16'd5, 8'd0, lat);
        chk("t3_latency", 32'(lat),           32'd1);
        chk("t3_q",       32'(quotient_out),  32'hFFFF);
        chk("t3_r",       32'(remainder_out), 32'h05);
        chk("t3_dbz",     32'(div_by_zero),   32'h1);
        tick();
        chk("t3_seg_err", 32'(seg),           32'(PE));
        chk("t3_done_1cyc", 32'(done_flag),   32'h0);
        repeat (3) tick();
        chk("t3_dbz_hold", 32'(div_by_zero),  32'h1);
        do_op(16'd100, 8'd10, lat);
        chk("t3b_q",       32'(quotient_out),  32'd10);
        chk("t3b_r",       32'(remainder_out), 32'd0);
        chk("t3b_dbz",     32'(div_by_zero),   32'h0);
        tick();

        // reset during CALC aborts cleanly
        start    = 1'b1;
        dividend = 16'd60000;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        repeat (8) tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        chk("t4_q",    32'(quotient_out),  32'h0);
        chk("t4_r",    32'(remainder_out), 32'h0);
        chk("t4_done", 32'(done_flag),     32'h0);
        chk("t4_dbz",  32'(div_by_zero),   32'h0);
        chk("t4_seg",  32'(seg),           32'(P0));
        no_done = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done_flag === 1'b1) no_done++;
        end
        chk("t4_no_done", 32'(no_done), 32'd0);
        do_op(16'd200, 8'd3, lat);
        chk("t4b_latency", 32'(lat),           32'd17);
        chk("t4b_q",       32'(quotient_out),  32'd66);
        chk("t4b_r",       32'(remainder_out), 32'd2);
        tick();

        // start held high; operands change during CALC of the first op and are
        // picked up only by the second. Period = LOAD + 16 CALC + DONE + IDLE.
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 8'd56;
        first  = -1;
        second = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 3) begin
                dividend = 16'd9999;
                divisor  = 8'd3;
            end
            if (done_flag === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    q1 = quotient_out;
                    r1 = remainder_out;
                end else if (second < 0) begin
                    second = k;
                    q2 = quotient_out;
                    r2 = remainder_out;
                end
            end
            seg_log[k] = seg;
        end
        start = 1'b0;
        chk("t5_first_done",  32'(first),  32'd17);
        chk("t5_second_done", 32'(second), 32'd36);
        chk("t5_q1", 32'(q1), 32'd22);
        chk("t5_r1", 32'(r1), 32'd2);
        chk("t5_q2", 32'(q2), 32'd3333);
        chk("t5_r2", 32'(r2), 32'd0);
        chk("t5_seg_load", 32'(seg_log[1]),  32'(P1));
        chk("t5_seg_calc", 32'(seg_log[2]),  32'(P2));
        chk("t5_seg_last", 32'(seg_log[17]), 32'(P2));
        chk("t5_seg_done", 32'(seg_log[18]), 32'(P3));
        chk("t5_seg_idle", 32'(seg_log[19]), 32'(P0));
        chk("t5_seg_next", 32'(seg_log[20]), 32'(P1));
        repeat (25) tick();

        // random sweep, first two divisors pinned to the extremes
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom_range(0, 65535));
            if (i == 0)      rb = 8'd1;
            else if (i == 1) rb = 8'd255;
            else             rb = 8'($urandom_range(1, 255));
            do_op(ra, rb, lat);
            chk("sweep_lat", 32'(lat), 32'd17);
            chk("sweep_qr", {8'h0, quotient_out, remainder_out},
                {8'h0, 16'(int'(ra) / int'(rb)), 8'(int'(ra) % int'(rb))});
            chk("sweep_identity",
                32'(((int'(quotient_out) * int'(rb) + int'(remainder_out)) == int'(ra))
                    && (remainder_out < rb)),
                32'd1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
